// File: rtl/gb_periph_bank_if.sv
// Host-side ghostbus port of the peripheral bank: address/data, write and read strobes,
// read data with valid pulse, and busy back-pressure.
interface gb_periph_bank_if #(
    parameter int AW = 12,
    parameter int DW = 32
) ();
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic          gb_we;
    logic          gb_re;
    logic [DW-1:0] gb_din;
    logic          gb_rvalid;
    logic          gb_busy;

    modport master (
        output gb_addr, gb_dout, gb_we, gb_re,
        input  gb_din, gb_rvalid, gb_busy
    );

    modport slave (
        input  gb_addr, gb_dout, gb_we, gb_re,
        output gb_din, gb_rvalid, gb_busy
    );
endinterface

// File: rtl/gb_periph_bank.sv
// Ghostbus peripheral bank: RW control registers, sticky STATUS, host RAM and an external
// sub-bus window with ack timeout, all behind one host port.
//
// state    | meaning
// IDLE     | accepting strobes; register/STATUS/unmapped accesses complete from here
// RAM_RD   | RAM word read, moving to the output register
// EXT_WAIT | ext strobe issued, down-counting toward timeout while waiting for ext_ack
module gb_periph_bank #(
    parameter int            AW        = 12,
    parameter int            DW        = 32,
    parameter int            NREG      = 4,
    parameter logic [DW-1:0] RESET_VAL = '0,
    parameter int            RAM_BASE  = 'h100,
    parameter int            RAM_AW    = 6,
    parameter int            EXT_BASE  = 'h200,
    parameter int            EXT_AW    = 2,
    parameter int            EXT_DW    = 8,
    parameter int            TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gb_periph_bank_if.slave      gb,
    output logic [NREG*DW-1:0]   reg_out,
    output logic [EXT_AW-1:0]    ext_addr,
    output logic [EXT_DW-1:0]    ext_wdata,
    output logic                 ext_we,
    output logic                 ext_re,
    input  logic [EXT_DW-1:0]    ext_rdata,
    input  logic                 ext_ack
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RAM_RD   = 2'd1;
    localparam logic [1:0] S_EXT_WAIT = 2'd2;

    localparam logic [AW-1:0] RAM_BASE_A = AW'(RAM_BASE);
    localparam logic [AW-1:0] EXT_BASE_A = AW'(EXT_BASE);

    logic [1:0]    state;
    logic          ext_rd;
    logic [7:0]    cnt;
    logic [1:0]    status;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] mem [2**RAM_AW];
    logic [DW-1:0] ram_q;
    logic [DW-1:0] reg_rdata;
    logic          busy, wr_acc, rd_acc;
    logic          hit_reg, hit_stat, hit_ram, hit_ext, unmapped;

    assign busy       = (state != S_IDLE);
    assign gb.gb_busy = busy;
    // write wins when both strobes arrive together
    assign wr_acc = gb.gb_we & ~busy;
    assign rd_acc = gb.gb_re & ~gb.gb_we & ~busy;

    assign hit_reg  = gb.gb_addr < AW'(NREG);
    assign hit_stat = gb.gb_addr == AW'(NREG);
    assign hit_ram  = (gb.gb_addr >> RAM_AW) == (RAM_BASE_A >> RAM_AW);
    assign hit_ext  = (gb.gb_addr >> EXT_AW) == (EXT_BASE_A >> EXT_AW);
    assign unmapped = ~(hit_reg | hit_stat | hit_ram | hit_ext);

    always_comb begin
        reg_rdata = '0;
        for (int k = 0; k < NREG; k++)
            if (gb.gb_addr == AW'(k)) reg_rdata = regs[k];
    end

    for (genvar k = 0; k < NREG; k++) begin : g_reg_out
        assign reg_out[k*DW +: DW] = regs[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) regs[k] <= RESET_VAL;
        end else if (wr_acc && hit_reg) begin
            for (int k = 0; k < NREG; k++)
                if (gb.gb_addr == AW'(k)) regs[k] <= gb.gb_dout;
        end
    end

    // RAM array is not reset; read port is registered, giving the two-cycle read path
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc && hit_ram) mem[gb.gb_addr[RAM_AW-1:0]] <= gb.gb_dout;
        ram_q <= mem[gb.gb_addr[RAM_AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ext_rd       <= 1'b0;
            cnt          <= '0;
            status       <= '0;
            gb.gb_din    <= '0;
            gb.gb_rvalid <= 1'b0;
            ext_addr     <= '0;
            ext_wdata    <= '0;
            ext_we       <= 1'b0;
            ext_re       <= 1'b0;
        end else begin
            gb.gb_rvalid <= 1'b0;
            ext_we       <= 1'b0;
            ext_re       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_acc) begin
                        if (hit_stat) begin
                            status <= status & ~gb.gb_dout[1:0];
                        end else if (hit_ext) begin
                            ext_addr  <= gb.gb_addr[EXT_AW-1:0];
                            ext_wdata <= gb.gb_dout[EXT_DW-1:0];
                            ext_we    <= 1'b1;
                            ext_rd    <= 1'b0;
                            cnt       <= 8'(TIMEOUT - 1);
                            state     <= S_EXT_WAIT;
                        end else if (unmapped) begin
                            status[1] <= 1'b1;
                        end
                    end else if (rd_acc) begin
                        if (hit_reg) begin
                            gb.gb_din    <= reg_rdata;
                            gb.gb_rvalid <= 1'b1;
                        end else if (hit_stat) begin
                            gb.gb_din    <= {{(DW-2){1'b0}}, status};
                            gb.gb_rvalid <= 1'b1;
                        end else if (hit_ram) begin
                            state <= S_RAM_RD;
                        end else if (hit_ext) begin
                            ext_addr <= gb.gb_addr[EXT_AW-1:0];
                            ext_re   <= 1'b1;
                            ext_rd   <= 1'b1;
                            cnt      <= 8'(TIMEOUT - 1);
                            state    <= S_EXT_WAIT;
                        end else begin
                            gb.gb_din    <= '0;
                            gb.gb_rvalid <= 1'b1;
                            status[1]    <= 1'b1;
                        end
                    end
                end
                S_RAM_RD: begin
                    gb.gb_din    <= ram_q;
                    gb.gb_rvalid <= 1'b1;
                    state        <= S_IDLE;
                end
                S_EXT_WAIT: begin
                    // cnt == 0 marks the last (TIMEOUT-th) wait cycle
                    if (ext_ack) begin
                        if (ext_rd) begin
                            gb.gb_din    <= DW'(ext_rdata);
                            gb.gb_rvalid <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else if (cnt == 8'd0) begin
                        status[0] <= 1'b1;
                        if (ext_rd) begin
                            gb.gb_din    <= '1;
                            gb.gb_rvalid <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gb_periph_bank.sv
// Directed bench for gb_periph_bank: registers, STATUS, RAM, ext window, timeout and reset abort.
module tb_gb_periph_bank;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [127:0] reg_out;
    logic [1:0]  ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_we, ext_re;
    logic [7:0]  ext_rdata = '0;
    logic        ext_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    gb_periph_bank_if #(.AW(12), .DW(32)) bus ();

    gb_periph_bank #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gb        (bus.slave),
        .reg_out   (reg_out),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_we    (ext_we),
        .ext_re    (ext_re),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drives a one-cycle strobe; returns at the negedge of the following cycle
    task automatic strobe(input logic [11:0] addr, input logic [31:0] data,
                          input logic we, input logic re);
        @(negedge clk);
        bus.gb_addr = addr;
        bus.gb_dout = data;
        bus.gb_we   = we;
        bus.gb_re   = re;
        @(negedge clk);
        bus.gb_we = 1'b0;
        bus.gb_re = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        strobe(addr, 32'h0, 1'b0, 1'b1);
        chk({tag, "_rvalid"}, 64'(bus.gb_rvalid), 64'd1);
        chk({tag, "_data"}, 64'(bus.gb_din), 64'(exp));
    endtask

    initial begin
        int k;
        bus.gb_addr = '0;
        bus.gb_dout = '0;
        bus.gb_we   = 1'b0;
        bus.gb_re   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_reg_out", 64'(reg_out[63:0]), 64'd0);
        chk("rst_rvalid", 64'(bus.gb_rvalid), 64'd0);
        chk("rst_busy", 64'(bus.gb_busy), 64'd0);
        chk("rst_ext_re", 64'({ext_we, ext_re}), 64'd0);

        for (int i = 0; i < 4; i++) begin
            strobe(12'(i), 32'h0, 1'b0, 1'b1);
            chk("rst_rd_rvalid", 64'(bus.gb_rvalid), 64'd1);
            chk("rst_rd_data", 64'(bus.gb_din), 64'd0);
            chk("rst_rd_busy", 64'(bus.gb_busy), 64'd0);
        end

        strobe(12'd2, 32'hA5A5_0001, 1'b1, 1'b0);
        chk("reg2_out", 64'(reg_out[95:64]), 64'hA5A5_0001);
        chk("reg2_wr_rvalid", 64'(bus.gb_rvalid), 64'd0);
        rd_reg("reg2_rb", 12'd2, 32'hA5A5_0001);

        // write+read together is a write only
        strobe(12'd1, 32'h0000_BEEF, 1'b1, 1'b1);
        chk("we_re_rvalid", 64'(bus.gb_rvalid), 64'd0);
        chk("we_re_reg1", 64'(reg_out[63:32]), 64'h0000_BEEF);

        strobe(12'h13F, 32'h1234, 1'b1, 1'b0);
        chk("ram_wr_busy", 64'(bus.gb_busy), 64'd0);
        strobe(12'h13F, 32'h0, 1'b0, 1'b1);
        chk("ram_rd_busy1", 64'(bus.gb_busy), 64'd1);
        chk("ram_rd_rv1", 64'(bus.gb_rvalid), 64'd0);
        bus.gb_addr = 12'd0;
        bus.gb_re   = 1'b1;
        @(negedge clk);
        chk("ram_rd_rv2", 64'(bus.gb_rvalid), 64'd1);
        chk("ram_rd_data", 64'(bus.gb_din), 64'h1234);
        chk("ram_rd_busy2", 64'(bus.gb_busy), 64'd0);
        bus.gb_addr = 12'd2;
        @(negedge clk);
        bus.gb_re = 1'b0;
        chk("b2b_rvalid", 64'(bus.gb_rvalid), 64'd1);
        chk("b2b_data", 64'(bus.gb_din), 64'hA5A5_0001);
        @(negedge clk);
        chk("ignored_re", 64'(bus.gb_rvalid), 64'd0);
        chk("din_hold", 64'(bus.gb_din), 64'hA5A5_0001);

        strobe(12'h201, 32'h0, 1'b0, 1'b1);
        chk("ext_re", 64'(ext_re), 64'd1);
        chk("ext_addr", 64'(ext_addr), 64'd1);
        chk("ext_busy", 64'(bus.gb_busy), 64'd1);
        @(negedge clk);
        chk("ext_re_pulse", 64'(ext_re), 64'd0);
        @(negedge clk);
        ext_ack   = 1'b1;
        ext_rdata = 8'h5C;
        @(negedge clk);
        ext_ack = 1'b0;
        chk("ext_rd_rvalid", 64'(bus.gb_rvalid), 64'd1);
        chk("ext_rd_data", 64'(bus.gb_din), 64'h0000_005C);
        chk("ext_rd_busy", 64'(bus.gb_busy), 64'd0);

        strobe(12'h203, 32'h0000_0077, 1'b1, 1'b0);
        chk("ext_we", 64'(ext_we), 64'd1);
        chk("ext_wdata", 64'(ext_wdata), 64'h77);
        chk("ext_waddr", 64'(ext_addr), 64'd3);
        ext_ack = 1'b1;
        @(negedge clk);
        ext_ack = 1'b0;
        chk("ext_wr_busy", 64'(bus.gb_busy), 64'd0);
        chk("ext_wr_norv", 64'(bus.gb_rvalid), 64'd0);
        rd_reg("stat_after_wr", 12'd4, 32'd0);

        strobe(12'h202, 32'h0, 1'b0, 1'b1);
        k = 1;
        while (!bus.gb_rvalid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("to_latency", 64'(k), 64'(TIMEOUT + 1));
        chk("to_data", 64'(bus.gb_din), 64'hFFFF_FFFF);
        rd_reg("stat_to", 12'd4, 32'd1);
        strobe(12'd4, 32'd1, 1'b1, 1'b0);
        rd_reg("stat_clr", 12'd4, 32'd0);

        rd_reg("unmapped", 12'h050, 32'd0);
        rd_reg("stat_unm", 12'd4, 32'd2);
        strobe(12'h051, 32'hDEAD, 1'b1, 1'b0);
        strobe(12'd4, 32'd2, 1'b1, 1'b0);
        rd_reg("stat_clr2", 12'd4, 32'd0);

        strobe(12'h200, 32'h0, 1'b0, 1'b1);
        chk("abort_pre_re", 64'(ext_re), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.gb_busy), 64'd0);
        chk("abort_ext_re", 64'(ext_re), 64'd0);
        chk("abort_rvalid", 64'(bus.gb_rvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg("post_rst", 12'd2, 32'd0);
        chk("post_rst_busy", 64'(bus.gb_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
